pwm_capture: RTL and testbench
==============================

// Module: pwm_capture
// PURPOSE
//   Receive-side companion to PWM_counter: measures an incoming PWM waveform (e.g. the LED drive).
//   Reports high time, period and integer duty percent, and flags a stuck-high or stuck-low input.
//   Sits between any PWM source and the display/debug logic; used for closed-loop checks of the PWM generator.
// PARAMETERS
//   CNT_W        27          width of the high/period counters (matches duty_cycleMulti7)
//   SYNC_STAGES  2           synchronizer flops on pwm_in (>=2)
//   TIMEOUT      100000000   clk cycles without an edge before the input is declared stuck; must be < 2**CNT_W
// PORTS
//   clk         in   1       system clock, all logic on rising edge
//   restart     in   1       asynchronous reset, active-high
//   pwm_in      in   1       asynchronous PWM input
//   high_cnt    out  CNT_W   clk cycles high in the last measured period
//   period_cnt  out  CNT_W   clk cycles in the last measured period (rise to rise)
//   duty_pct    out  7       floor(high_cnt*100/period_cnt), 0..100
//   meas_valid  out  1       one-cycle pulse: all result outputs were just updated
//   busy        out  1       divider running
//   stuck       out  1       input has not toggled for TIMEOUT cycles
// BEHAVIOUR
// - Reset: all outputs 0; synchronizer 0; capture FSM to ARM; divider to IDLE.
//   Reset mid-divide aborts the divide with no meas_valid.
// - Input path: SYNC_STAGES flops, then one edge-detect flop.
//   Edge detection is a fixed delay and cancels out of the counts.
//   No glitch filter.
// - Capture FSM; the counter increments every cycle and saturates at 2**CNT_W-1.
//   - ARM: wait for a detected rise, then cnt<=1 and go to HIGH.
//     A fall is ignored in ARM.
//   - HIGH: on a detected fall, hi<=cnt, cnt<=cnt+1, go to LOW.
//   - LOW: on a detected rise, hand the capture (hi, cnt) to the divider, then cnt<=1 and go to HIGH.
//   - If the divider is busy, the new capture is dropped and the previous results are held.
// - Divider: restoring division of hi*100 (CNT_W+7 bits) by per.
//   - Computes one quotient bit per cycle, MSB first, 7 cycles total; busy=1 throughout.
//   - On the cycle after the last iteration, high_cnt/period_cnt/duty_pct update together and meas_valid=1.
//   - Latency: the rise-detect cycle T gives meas_valid in cycle T+8.
//   - Minimum period with every capture reported: 8 cycles.
//   - per>=2 always, so there is no divide-by-zero path.
// - Timeout: a cycle counter clears on any detected edge.
//   - When it reaches TIMEOUT: stuck<=1, high_cnt<=0, period_cnt<=0, and meas_valid pulses once.
//   - duty_pct<=100 if the synced level is 1, else 0.
//   - The FSM goes to ARM and the divider is aborted.
//   - stuck stays 1 until the next divider result is published.
//   - An edge detected in the same cycle as the timeout wins: no timeout.
// - First rise after reset or timeout only arms.
//   The first result follows the second rise.
// TESTING
//   1. Period 10, high 3, repeated -> high_cnt=3, period_cnt=10, duty_pct=30; meas_valid 8 cycles after each 2nd+ rise.
//   2. Period 7 high 1 -> duty 14.
//      Period 3 high 2 -> duty 66 for the first result; captures during busy are dropped and outputs hold.
//   3. TIMEOUT=1000; hold pwm_in=1 after a valid period -> at 1000 cycles: stuck=1, duty 100, counts 0, one meas_valid.
//      Same with pwm_in=0 -> duty 0.
//      The next two rises clear stuck.
//   4. Assert restart during busy -> all outputs 0 immediately, no meas_valid.
//      After release, the first rise only arms.
//   5. TIMEOUT=1000, period 999, high 500 -> no stuck; duty 50.
//      Edge exactly at timeout cycle -> no stuck.
//   6. Loop PWM_counter led -> pwm_in at several duty settings -> duty_pct equals the programmed percent (floor).

Source files
------------

// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform. It reports the high time,
// the period (rise to rise) and the integer duty percent, and it flags an
// input that has stopped toggling.
module pwm_capture #(
  parameter int unsigned CNT_W       = 27,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 100000000
) (
  input  logic             clk,
  input  logic             restart,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [6:0]       duty_pct,
  output logic             meas_valid,
  output logic             busy,
  output logic             stuck
);

  localparam int unsigned      DIV_W   = CNT_W + 7;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_END  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_ARM  = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [CNT_W-1:0]       r_to;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_hi;
  logic [DIV_W-1:0]       r_rem;
  logic [DIV_W-1:0]       r_dsh;
  logic [5:0]             r_q;
  logic [2:0]             r_iter;
  logic [CNT_W-1:0]       r_div_hi;
  logic [CNT_W-1:0]       r_div_per;

  logic             w_lvl;
  logic             w_rise;
  logic             w_fall;
  logic             w_edge;
  logic             w_timeout;
  logic             w_start;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_ge;
  logic [6:0]       w_q;
  logic [DIV_W-1:0] w_rem_nx;

  assign w_lvl     = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_lvl & ~r_prev;
  assign w_fall    = ~w_lvl & r_prev;
  assign w_edge    = w_rise | w_fall;
  // An edge in the same cycle as the would-be timeout takes precedence.
  assign w_timeout = ~w_edge & (r_to == TO_LAST);
  assign w_start   = (r_state == S_LOW) & w_rise & ~busy;
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_ge      = (r_rem >= r_dsh);
  assign w_q       = {r_q, w_ge};
  assign w_rem_nx  = w_ge ? (r_rem - r_dsh) : r_rem;

  // Synchronize the asynchronous input, then delay one cycle for edge detect.
  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      r_prev <= w_lvl;
    end
  end

  // Idle counter: cleared by any edge, parks at TIMEOUT so it fires only once.
  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      r_to <= '0;
    end else if (w_edge) begin
      r_to <= '0;
    end else if (r_to != TO_END) begin
      r_to <= r_to + CNT_W'(1);
    end
  end

  // Capture FSM: counts high time and period; a dropped capture still restarts the period.
  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      r_state <= S_ARM;
      r_cnt   <= '0;
      r_hi    <= '0;
    end else if (w_timeout) begin
      r_state <= S_ARM;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_ARM: begin
          if (w_rise) begin
            r_cnt   <= CNT_W'(1);
            r_state <= S_HIGH;
          end
        end
        S_HIGH: begin
          r_cnt <= w_cnt_inc;
          if (w_fall) begin
            r_hi    <= r_cnt;
            r_state <= S_LOW;
          end
        end
        S_LOW: begin
          if (w_rise) begin
            r_cnt   <= CNT_W'(1);
            r_state <= S_HIGH;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= S_ARM;
      endcase
    end
  end

  // Restoring divider (7 quotient bits, MSB first) and result publication.
  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      r_rem      <= '0;
      r_dsh      <= '0;
      r_q        <= '0;
      r_iter     <= '0;
      r_div_hi   <= '0;
      r_div_per  <= '0;
      high_cnt   <= '0;
      period_cnt <= '0;
      duty_pct   <= '0;
      meas_valid <= 1'b0;
      busy       <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (w_timeout) begin
        busy       <= 1'b0;
        stuck      <= 1'b1;
        high_cnt   <= '0;
        period_cnt <= '0;
        duty_pct   <= w_lvl ? 7'd100 : 7'd0;
        meas_valid <= 1'b1;
      end else if (w_start) begin
        busy      <= 1'b1;
        r_rem     <= DIV_W'(r_hi) * DIV_W'(100);
        r_dsh     <= DIV_W'(r_cnt) << 6;
        r_q       <= '0;
        r_iter    <= '0;
        r_div_hi  <= r_hi;
        r_div_per <= r_cnt;
      end else if (busy) begin
        r_rem  <= w_rem_nx;
        r_dsh  <= r_dsh >> 1;
        r_q    <= w_q[5:0];
        r_iter <= r_iter + 3'd1;
        if (r_iter == 3'd6) begin
          busy       <= 1'b0;
          high_cnt   <= r_div_hi;
          period_cnt <= r_div_per;
          duty_pct   <= w_q;
          stuck      <= 1'b0;
          meas_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with hand-computed expectations.
module tb_pwm_capture;

  localparam int unsigned CNT_W = 27;

  logic             clk = 1'b0;
  logic             restart;
  logic             pwm_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic [6:0]       duty_pct;
  logic             meas_valid;
  logic             busy;
  logic             stuck;

  int checks = 0;
  int errors = 0;
  int idx, pulses, first_idx, stuck_idx;
  bit stuck_seen;

  pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(2), .TIMEOUT(1000)) dut (
    .clk       (clk),
    .restart   (restart),
    .pwm_in    (pwm_in),
    .high_cnt  (high_cnt),
    .period_cnt(period_cnt),
    .duty_pct  (duty_pct),
    .meas_valid(meas_valid),
    .busy      (busy),
    .stuck     (stuck)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    idx        = 0;
    pulses     = 0;
    first_idx  = -1;
    stuck_idx  = -1;
    stuck_seen = 1'b0;
  endtask

  // One clock; sample #1 after the rising edge and log pulses / stuck.
  task automatic step();
    @(posedge clk);
    #1;
    if (meas_valid === 1'b1) begin
      if (pulses == 0) first_idx = idx;
      pulses++;
    end
    if (stuck === 1'b1 && !stuck_seen) begin
      stuck_seen = 1'b1;
      stuck_idx  = idx;
    end
    idx++;
  endtask

  task automatic hold(input logic lvl, input int n);
    pwm_in = lvl;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run(input int h, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < p; i++) begin
        pwm_in = (i < h);
        step();
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_high"},  64'(high_cnt),   64'd0);
    chk({tag, "_per"},   64'(period_cnt), 64'd0);
    chk({tag, "_duty"},  64'(duty_pct),   64'd0);
    chk({tag, "_valid"}, 64'(meas_valid), 64'd0);
    chk({tag, "_busy"},  64'(busy),       64'd0);
    chk({tag, "_stuck"}, 64'(stuck),      64'd0);
  endtask

  initial begin
    restart = 1'b1;
    pwm_in  = 1'b0;
    clear_mon();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    restart = 1'b0;

    // Period 10, high 3: first rise arms, results 8 cycles after each later rise.
    clear_mon();
    run(3, 10, 4);
    chk("p10_pulses", 64'(pulses), 64'd3);
    chk("p10_first",  64'(first_idx), 64'd19);
    chk("p10_high",   64'(high_cnt), 64'd3);
    chk("p10_per",    64'(period_cnt), 64'd10);
    chk("p10_duty",   64'(duty_pct), 64'd30);
    chk("p10_stuck",  64'(stuck), 64'd0);

    // Period 7 high 1: every other capture falls on a busy divider.
    clear_mon();
    run(1, 7, 4);
    chk("p7_pulses", 64'(pulses), 64'd2);
    chk("p7_first",  64'(first_idx), 64'd9);
    chk("p7_high",   64'(high_cnt), 64'd1);
    chk("p7_per",    64'(period_cnt), 64'd7);
    chk("p7_duty",   64'(duty_pct), 64'd14);

    // Period 3 high 2 from a fresh reset.
    restart = 1'b1;
    step();
    step();
    restart = 1'b0;
    clear_mon();
    run(2, 3, 5);
    chk("p3_pulses", 64'(pulses), 64'd1);
    chk("p3_first",  64'(first_idx), 64'd12);
    chk("p3_high",   64'(high_cnt), 64'd2);
    chk("p3_per",    64'(period_cnt), 64'd3);
    chk("p3_duty",   64'(duty_pct), 64'd66);
    clear_mon();
    hold(1'b0, 20);
    chk("p3_hold_pulses", 64'(pulses), 64'd1);
    chk("p3_hold_duty",   64'(duty_pct), 64'd66);

    // Stuck high after valid periods.
    run(3, 10, 3);
    clear_mon();
    hold(1'b1, 1100);
    chk("sh_pulses", 64'(pulses), 64'd2);
    chk("sh_at",     64'(stuck_idx), 64'd1002);
    chk("sh_stuck",  64'(stuck), 64'd1);
    chk("sh_duty",   64'(duty_pct), 64'd100);
    chk("sh_high",   64'(high_cnt), 64'd0);
    chk("sh_per",    64'(period_cnt), 64'd0);
    clear_mon();
    hold(1'b1, 1200);
    chk("sh_no_refire", 64'(pulses), 64'd0);

    // Stuck low.
    clear_mon();
    hold(1'b0, 1100);
    chk("sl_pulses", 64'(pulses), 64'd1);
    chk("sl_duty",   64'(duty_pct), 64'd0);
    chk("sl_stuck",  64'(stuck), 64'd1);

    // Two rises clear stuck; the first only arms.
    clear_mon();
    run(3, 10, 1);
    chk("rearm_pulses", 64'(pulses), 64'd0);
    chk("rearm_stuck",  64'(stuck), 64'd1);
    run(3, 10, 1);
    hold(1'b0, 5);
    chk("clr_pulses", 64'(pulses), 64'd1);
    chk("clr_stuck",  64'(stuck), 64'd0);
    chk("clr_duty",   64'(duty_pct), 64'd30);

    // Period 999 high 500 never times out.
    clear_mon();
    run(500, 999, 3);
    chk("p999_stuck", 64'(stuck_seen), 64'd0);
    chk("p999_high",  64'(high_cnt), 64'd500);
    chk("p999_per",   64'(period_cnt), 64'd999);
    chk("p999_duty",  64'(duty_pct), 64'd50);

    // Edge gap of exactly 1000 cycles wins over the timeout; 1001 does not.
    clear_mon();
    hold(1'b1, 1000);
    hold(1'b0, 1000);
    hold(1'b1, 1001);
    chk("gap1000_stuck", 64'(stuck_seen), 64'd0);
    hold(1'b0, 5);
    chk("gap1001_stuck", 64'(stuck_seen), 64'd1);
    chk("gap1001_duty",  64'(duty_pct), 64'd100);
    chk("gap1001_high",  64'(high_cnt), 64'd0);

    // Restart while the divider is busy.
    run(3, 10, 1);
    pwm_in = 1'b1;
    clear_mon();
    repeat (4) step();
    chk("rst_busy_before", 64'(busy), 64'd1);
    restart = 1'b1;
    #1;
    chk_zero("rst_mid");
    pwm_in = 1'b0;
    step();
    step();
    restart = 1'b0;
    clear_mon();
    hold(1'b0, 20);
    run(3, 10, 1);
    hold(1'b0, 20);
    chk("rst_arm_pulses", 64'(pulses), 64'd0);
    run(3, 10, 1);
    hold(1'b0, 5);
    chk("rst_res_pulses", 64'(pulses), 64'd1);
    chk("rst_res_high",   64'(high_cnt), 64'd3);
    chk("rst_res_per",    64'(period_cnt), 64'd30);
    chk("rst_res_duty",   64'(duty_pct), 64'd10);

    // Generator-style duty settings.
    clear_mon();
    run(25, 100, 3);
    chk("d25", 64'(duty_pct), 64'd25);
    run(50, 100, 3);
    chk("d50", 64'(duty_pct), 64'd50);
    run(99, 100, 3);
    chk("d99", 64'(duty_pct), 64'd99);
    run(37, 64, 3);
    chk("d37_64", 64'(duty_pct), 64'd57);
    chk("d37_64_per", 64'(period_cnt), 64'd64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
